// File: rtl/pixel_window_feeder_if.sv
// Pixel stream in, 2x3 window out, for the six-operand filter front end.
//
// Handshake: valid-only, no ready. pix_in and sof are sampled on a rising
// clk edge when pix_valid is high, and the pixel is always taken. Downstream
// is always ready: A..F are meaningful in any cycle where win_valid is high,
// and win_eof is only meaningful together with win_valid.
interface pixel_window_feeder_if #(
    parameter int PIX_W = 8
);
    logic [PIX_W-1:0] pix_in;
    logic             pix_valid;
    logic             sof;
    logic [PIX_W-1:0] A;
    logic [PIX_W-1:0] B;
    logic [PIX_W-1:0] C;
    logic [PIX_W-1:0] D;
    logic [PIX_W-1:0] E;
    logic [PIX_W-1:0] F;
    logic             win_valid;
    logic             win_eof;
    logic             busy;
    logic             dbg_state;   // 0 = WAIT_SOF, 1 = ACTIVE

    modport master (
        output pix_in, pix_valid, sof,
        input  A, B, C, D, E, F, win_valid, win_eof, busy, dbg_state
    );

    modport slave (
        input  pix_in, pix_valid, sof,
        output A, B, C, D, E, F, win_valid, win_eof, busy, dbg_state
    );
endinterface

// File: rtl/pixel_window_feeder.sv
// Builds a 2-row x 3-column window from a raster pixel stream, using a
// one-line buffer (previous row) and two 3-deep tap shift registers.
// A/B/C are the row above, D/E/F the current row, oldest column first.
module pixel_window_feeder #(
    parameter int PIX_W = 8,
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int CNT_W = 10
) (
    input logic clk,
    input logic reset,
    pixel_window_feeder_if.slave bus
);
    localparam int AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;

    typedef enum logic {
        WAIT_SOF = 1'b0,
        ACTIVE   = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] col;
    logic [CNT_W-1:0] row;
    logic [CNT_W-1:0] cur_col;
    logic [CNT_W-1:0] cur_row;
    logic [CNT_W-1:0] col_next;
    logic [CNT_W-1:0] row_next;
    logic             start;
    logic             accept;
    logic             at_eol;
    logic             at_eof;
    logic             win_hit;
    logic [PIX_W-1:0] lb_rd;
    logic [PIX_W-1:0] line_buf [0:IMG_W-1];
    logic [PIX_W-1:0] u0, u1, u2;
    logic [PIX_W-1:0] l0, l1, l2;
    logic             win_valid_q;
    logic             win_eof_q;
    logic             busy_q;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= WAIT_SOF;
        else        state <= state_next;
    end

    // Next state: any accepted pixel keeps us ACTIVE unless it closes the frame.
    always_comb begin
        state_next = state;
        if (accept) state_next = at_eof ? WAIT_SOF : ACTIVE;
    end

    // Accept/position decode; sof overrides the counters so that pixel is (0,0).
    always_comb begin
        start    = bus.pix_valid & bus.sof;
        accept   = bus.pix_valid & (bus.sof | (state == ACTIVE));
        cur_col  = start ? '0 : col;
        cur_row  = start ? '0 : row;
        at_eol   = (cur_col == CNT_W'(IMG_W - 1));
        at_eof   = at_eol && (cur_row == CNT_W'(IMG_H - 1));
        win_hit  = accept && (cur_row >= CNT_W'(1)) && (cur_col >= CNT_W'(2));
        lb_rd    = line_buf[cur_col[AW-1:0]];
        col_next = col;
        row_next = row;
        if (accept) begin
            if (at_eol) begin
                col_next = '0;
                row_next = at_eof ? '0 : cur_row + CNT_W'(1);
            end else begin
                col_next = cur_col + CNT_W'(1);
                row_next = cur_row;
            end
        end
    end

    // Counters, tap shift registers and registered strobes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col         <= '0;
            row         <= '0;
            u0          <= '0;
            u1          <= '0;
            u2          <= '0;
            l0          <= '0;
            l1          <= '0;
            l2          <= '0;
            win_valid_q <= 1'b0;
            win_eof_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            col         <= col_next;
            row         <= row_next;
            win_valid_q <= win_hit;
            win_eof_q   <= accept && at_eof;
            busy_q      <= (state_next == ACTIVE);
            if (accept) begin
                u2 <= u1;
                u1 <= u0;
                u0 <= lb_rd;
                l2 <= l1;
                l1 <= l0;
                l0 <= bus.pix_in;
            end
        end
    end

    // Line buffer write; the read above sees the previous row's value first.
    always_ff @(posedge clk) begin
        if (accept) line_buf[cur_col[AW-1:0]] <= bus.pix_in;
    end

    assign bus.A         = u2;
    assign bus.B         = u1;
    assign bus.C         = u0;
    assign bus.D         = l2;
    assign bus.E         = l1;
    assign bus.F         = l0;
    assign bus.win_valid = win_valid_q;
    assign bus.win_eof   = win_eof_q;
    assign bus.busy      = busy_q;
    assign bus.dbg_state = state;
endmodule

// File: tb/tb_pixel_window_feeder.sv
// Bench for pixel_window_feeder on a 4x3 image: directed frames plus random
// streams, checked against a frame-image reference model.
module tb_pixel_window_feeder;
    localparam int PIX_W = 8;
    localparam int IMG_W = 4;
    localparam int IMG_H = 3;

    logic clk = 1'b0;
    logic reset = 1'b0;

    pixel_window_feeder_if #(.PIX_W(PIX_W)) bus ();

    pixel_window_feeder #(
        .PIX_W(PIX_W),
        .IMG_W(IMG_W),
        .IMG_H(IMG_H),
        .CNT_W(10)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // Clock.
    always #5 clk = ~clk;

    int total = 0;
    int passed = 0;
    int fails = 0;
    int win_count = 0;

    // Reference model: the pixels of the current frame, by position.
    bit         m_active;
    int         m_row;
    int         m_col;
    logic [7:0] img [IMG_H][IMG_W];
    logic [7:0] last_win [6];
    bit         held_ok;
    bit         exp_valid;
    bit         exp_eof;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_active = 1'b0;
        m_row    = 0;
        m_col    = 0;
        held_ok  = 1'b1;
        for (int i = 0; i < 6; i++) last_win[i] = 8'h00;
        exp_valid = 1'b0;
        exp_eof   = 1'b0;
    endtask

    task automatic model_step(input bit v, input bit s, input logic [7:0] p);
        exp_valid = 1'b0;
        exp_eof   = 1'b0;
        if (v && (s || m_active)) begin
            if (s) begin
                m_row = 0;
                m_col = 0;
            end
            img[m_row][m_col] = p;
            if (m_row >= 1 && m_col >= 2) begin
                exp_valid   = 1'b1;
                exp_eof     = (m_row == IMG_H - 1) && (m_col == IMG_W - 1);
                last_win[0] = img[m_row-1][m_col-2];
                last_win[1] = img[m_row-1][m_col-1];
                last_win[2] = img[m_row-1][m_col];
                last_win[3] = img[m_row][m_col-2];
                last_win[4] = img[m_row][m_col-1];
                last_win[5] = img[m_row][m_col];
                held_ok     = 1'b1;
            end else begin
                held_ok = 1'b0;
            end
            m_col++;
            if (m_col == IMG_W) begin
                m_col = 0;
                m_row++;
            end
            if (m_row == IMG_H) begin
                m_row    = 0;
                m_active = 1'b0;
            end else begin
                m_active = 1'b1;
            end
        end
    endtask

    function automatic logic [63:0] dut_win();
        return 64'({bus.A, bus.B, bus.C, bus.D, bus.E, bus.F});
    endfunction

    function automatic logic [63:0] model_win();
        return 64'({last_win[0], last_win[1], last_win[2],
                    last_win[3], last_win[4], last_win[5]});
    endfunction

    // Scoreboard: compare DUT against the model after each edge.
    task automatic check_outputs();
        chk("win_valid", 64'(bus.win_valid), 64'(exp_valid));
        chk("win_eof", 64'(bus.win_eof), 64'(exp_eof));
        chk("busy", 64'(bus.busy), 64'(m_active));
        chk("state", 64'(bus.dbg_state), 64'(m_active));
        if (held_ok) chk("window", dut_win(), model_win());
        if (bus.win_valid === 1'b1) win_count++;
    endtask

    // Driver: one cycle of input, then sample 1 time unit after the edge.
    task automatic step(input bit v, input bit s, input logic [7:0] p);
        bus.pix_valid = v;
        bus.sof       = s;
        bus.pix_in    = p;
        @(posedge clk);
        #1;
        model_step(v, s, p);
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'($urandom_range(0, 255)));
    endtask

    // Pixels of a frame by raster index, value row*16+col, sof at index 0.
    task automatic frame_part(input int from_idx, input int to_idx);
        for (int i = from_idx; i <= to_idx; i++) begin
            step(1'b1, i == 0, 8'((i / IMG_W) * 16 + (i % IMG_W)));
        end
    endtask

    initial begin
        bus.pix_valid = 1'b0;
        bus.sof       = 1'b0;
        bus.pix_in    = '0;
        model_reset();

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_window", dut_win(), 64'h0);
        chk("rst_win_valid", 64'(bus.win_valid), 64'h0);
        chk("rst_win_eof", 64'(bus.win_eof), 64'h0);
        chk("rst_busy", 64'(bus.busy), 64'h0);
        #1 reset = 1'b1;

        // Full frame: 4 windows, last one is 11,12,13,21,22,23 with eof.
        win_count = 0;
        frame_part(0, 11);
        chk("t2_count", 64'(win_count), 64'd4);
        chk("t3_last_win", dut_win(), 64'h1112_1321_2223);
        chk("t3_last_eof", 64'(bus.win_eof), 64'h1);
        idle(1);
        chk("t3_busy_after", 64'(bus.busy), 64'h0);

        // Gap of 3 idle cycles after pixel (1,2).
        win_count = 0;
        frame_part(0, 6);
        chk("t4_first_win", dut_win(), 64'h0001_0210_1112);
        idle(3);
        chk("t4_held_win", dut_win(), 64'h0001_0210_1112);
        frame_part(7, 11);
        chk("t4_count", 64'(win_count), 64'd4);

        // Asynchronous reset mid-frame, then pixels without sof.
        frame_part(0, 6);
        #2 reset = 1'b0;
        #1;
        chk("t1_window", dut_win(), 64'h0);
        chk("t1_win_valid", 64'(bus.win_valid), 64'h0);
        chk("t1_win_eof", 64'(bus.win_eof), 64'h0);
        chk("t1_busy", 64'(bus.busy), 64'h0);
        model_reset();
        @(posedge clk);
        #2 reset = 1'b1;
        win_count = 0;
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 8'($urandom_range(0, 255)));
        chk("t1_no_win", 64'(win_count), 64'd0);

        // Restart with sof at pixel (2,1).
        win_count = 0;
        frame_part(0, 8);
        chk("t5_aborted_count", 64'(win_count), 64'd2);
        win_count = 0;
        frame_part(0, 6);
        chk("t5_new_first", dut_win(), 64'h0001_0210_1112);
        frame_part(7, 11);
        chk("t5_new_count", 64'(win_count), 64'd4);

        // Back-to-back frames.
        win_count = 0;
        frame_part(0, 11);
        frame_part(0, 6);
        chk("t6_second_first", dut_win(), 64'h0001_0210_1112);
        frame_part(7, 11);
        chk("t6_count", 64'(win_count), 64'd8);

        // Random pixels, random gaps and random restarts.
        step(1'b1, 1'b1, 8'($urandom_range(0, 255)));
        for (int i = 0; i < 400; i++) begin
            bit v;
            bit s;
            v = ($urandom_range(0, 3) != 0);
            if (!m_active) s = v && ($urandom_range(0, 3) == 0);
            else           s = v && ($urandom_range(0, 30) == 0);
            step(v, s, 8'($urandom_range(0, 255)));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/pixel_window_feeder.md
Name: pixel_window_feeder

Overview:
- Streaming producer that feeds the six-operand filter datapath (the six-input adder's coefficient-multiply front end).
- Accepts raster-order pixels one per cycle and builds a 2-row x 3-column window from a one-line circular buffer plus tap shift registers.
- Emits the six window pixels A..F in parallel with a valid strobe and an end-of-frame marker.
- No backpressure: the downstream pipeline is always ready.

Parameters:
- PIX_W, 8, pixel bit width (unsigned).
- IMG_W, 640, pixels per line; legal range 3..1023.
- IMG_H, 480, lines per frame; legal range 2..1023.
- CNT_W, 10, bit width of the column and row counters.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- pix_in  in  PIX_W  input pixel.
- pix_valid  in  1  pix_in is valid this cycle (accepted unconditionally).
- sof  in  1  start of frame; qualified by pix_valid; marks pixel (0,0).
- A,B,C  out  PIX_W each  upper row (r-1), columns c-2, c-1, c.
- D,E,F  out  PIX_W each  current row r, columns c-2, c-1, c.
- win_valid  out  1  A..F hold a complete window.
- win_eof  out  1  with win_valid, marks the last window of the frame.
- busy  out  1  high while in ACTIVE state.

Behaviour:
- Reset (reset=0, async):
  - A..F=0, win_valid=0, win_eof=0, busy=0.
  - Column and row counters = 0; tap shift registers = 0; state = WAIT_SOF.
  - Line buffer contents are don't-care.
- FSM has two states:
  - WAIT_SOF: pixels without sof are discarded. On pix_valid&sof: accept as (0,0), go to ACTIVE.
  - ACTIVE: each pix_valid pixel is accepted at (row,col).
    - col increments; at col=IMG_W-1 col wraps to 0 and row increments.
    - Accepting (IMG_H-1, IMG_W-1) returns the FSM to WAIT_SOF.
- Restart: pix_valid&sof in ACTIVE restarts the frame.
  - Counters are forced so this pixel is (0,0).
  - Window validity restarts; no window straddles frames.
- Line buffer:
  - IMG_W entries, addressed by col.
  - Read-before-write in the same cycle: the old value (row r-1, col c) is read and pix_in is written.
  - On row 0, read data is garbage, but no window is emitted there.
- Tap shift registers:
  - Upper row: U2<=U1, U1<=U0, U0<=linebuf_rd.
  - Lower row: L2<=L1, L1<=L0, L0<=pix_in.
  - Both shift only on accepted pixels.
- Output timing:
  - Latency is 1 cycle: for the pixel accepted in cycle n, outputs update at edge n+1.
  - Outputs: A=U2, B=U1, C=U0 and D=L2, E=L1, F=L0, meaning columns c-2, c-1, c.
  - win_valid=1 in cycle n+1 iff the accepted pixel has row>=1 and col>=2.
  - win_eof=1 iff that pixel is (IMG_H-1, IMG_W-1).
- Windows never wrap horizontally: col 0 and col 1 of each row give win_valid=0.
- Windows per frame = (IMG_H-1)*(IMG_W-2).
- Idle cycles (pix_valid=0):
  - win_valid and win_eof drop to 0 the next cycle.
  - A..F, the counters and the FSM state hold.
- Pixels are passed through unmodified, with no sign extension. Width adaptation to the adder's input happens downstream.
- busy mirrors state==ACTIVE, registered.
- Reset asserted mid-frame: all outputs go to 0 immediately. After release, the block waits for the next sof.

Test Plan (IMG_W=4, IMG_H=3, pixel value = row*16+col, continuous pix_valid):
1. Reset asserted mid-stream -> A..F, win_valid, win_eof and busy read 0 within the same cycle; after release, pixels without sof produce no win_valid.
2. Full frame -> exactly 4 win_valid pulses, on the cycles after pixels (1,2),(1,3),(2,2),(2,3). First window: A..F = 00,01,02,10,11,12.
3. Last window -> A..F = 11,12,13,21,22,23 with win_eof=1; busy=0 the next cycle.
4. Same frame with pix_valid deasserted for 3 cycles after pixel (1,2) -> window values unchanged; win_valid low during the gap; A..F held.
5. sof reasserted at pixel (2,1) of a frame -> no window emitted for the aborted frame's remainder. The next windows are those of the new frame, first after new pixel (1,2).
6. Back-to-back frames with sof on the cycle after win_eof -> 8 windows total, no lost pixels. The second frame's first window matches step 2.
